// File: rtl/marc_pkg.sv
// Shared encodings for the MARC control unit: FSM states, opcode fields,
// ALU operation codes and the control-word layout.
package marc_pkg;

    typedef enum logic [2:0] {
        StFetch   = 3'd0,
        StWaitIf  = 3'd1,
        StDecode  = 3'd2,
        StExec    = 3'd3,
        StMem     = 3'd4,
        StWaitMem = 3'd5,
        StHalt    = 3'd6
    } state_e;

    // Major opcodes, instruction[15:14]
    localparam logic [1:0] OP_BRANCH = 2'b00;
    localparam logic [1:0] OP_SETLOW = 2'b01;
    localparam logic [1:0] OP_ARITH  = 2'b10;
    localparam logic [1:0] OP_MEMORY = 2'b11;

    // Arithmetic function codes map straight onto ALU codes 0..3
    localparam logic [1:0] FN_ADD = 2'd0;
    localparam logic [1:0] FN_SUB = 2'd1;
    localparam logic [1:0] FN_AND = 2'd2;
    localparam logic [1:0] FN_OR  = 2'd3;

    // Branch conditions, instruction[13:10]
    localparam logic [3:0] COND_Z      = 4'b0001;
    localparam logic [3:0] COND_N      = 4'b0010;
    localparam logic [3:0] COND_C      = 4'b0011;
    localparam logic [3:0] COND_V      = 4'b0100;
    localparam logic [3:0] COND_ALWAYS = 4'b1000;
    localparam logic [3:0] COND_NZ     = 4'b1001;
    localparam logic [3:0] COND_HALT   = 4'b1111;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_PASSA = 4'd4;
    localparam logic [3:0] ALU_INC   = 4'd5;
    localparam logic [3:0] ALU_IMM   = 4'd6;
    localparam logic [3:0] ALU_ADDD  = 4'd7;

    // Control-word field positions (LSB of each field)
    localparam int unsigned ASEL_LSB  = 16;
    localparam int unsigned BSEL_LSB  = 12;
    localparam int unsigned CSEL_LSB  = 8;
    localparam int unsigned ALUOP_LSB = 4;
    localparam int unsigned REGWR_BIT = 3;
    localparam int unsigned MEMRD_BIT = 2;
    localparam int unsigned MEMWR_BIT = 1;
    localparam int unsigned IRLD_BIT  = 0;

    // Packed so that the field order reproduces the bit positions above
    typedef struct packed {
        logic [3:0] asel;
        logic [3:0] bsel;
        logic [3:0] csel;
        logic [3:0] aluop;
        logic       regwr;
        logic       memrd;
        logic       memwr;
        logic       irld;
    } ctrl_t;

    localparam ctrl_t NOP = '0;

    localparam int unsigned PC_REG = 15;

endpackage

// File: rtl/branch_eval.sv
// Branch condition evaluator: decides whether a conditional branch is taken.
module branch_eval
    import marc_pkg::*;
(
    input  logic [3:0] cond,
    input  logic       n,
    input  logic       z,
    input  logic       v,
    input  logic       c,
    output logic       taken
);

    // Unlisted condition codes are never taken; the halt code is handled upstream
    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_ALWAYS: taken = 1'b1;
            COND_Z:      taken = z;
            COND_NZ:     taken = ~z;
            COND_N:      taken = n;
            COND_C:      taken = c;
            COND_V:      taken = v;
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit: sequences fetch/decode/execute/memory phases and
// produces the datapath control word combinationally from state and instruction.
module control_unit
    import marc_pkg::*;
#(
    parameter int unsigned PC_REG = marc_pkg::PC_REG,
    parameter int unsigned IW     = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [IW-1:0] instruction,
    input  logic [4:0]    status,
    output logic [19:0]   ctrlword,
    output logic [2:0]    state,
    output logic          halted
);

    localparam logic [3:0] PC_SEL = 4'(PC_REG);

    state_e state_q, state_d;
    ctrl_t  cw;
    logic   taken;

    logic [1:0] op;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [1:0] fn;
    logic       mem_ready;

    assign op        = instruction[15:14];
    assign rd        = instruction[13:10];
    assign rs1       = instruction[9:6];
    assign rs2       = instruction[5:2];
    assign fn        = instruction[1:0];
    assign mem_ready = status[0];

    branch_eval u_branch_eval (
        .cond  (rd),
        .n     (status[4]),
        .z     (status[3]),
        .v     (status[2]),
        .c     (status[1]),
        .taken (taken)
    );

    // State register; reset aborts any pending fetch or memory wait
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control-word decode
    always_comb begin
        state_d = state_q;
        cw      = NOP;
        case (state_q)
            StFetch: begin
                cw.asel  = PC_SEL;
                cw.aluop = ALU_PASSA;
                cw.memrd = 1'b1;
                state_d  = StWaitIf;
            end
            StWaitIf: begin
                cw.asel  = PC_SEL;
                cw.aluop = ALU_PASSA;
                cw.memrd = 1'b1;
                if (mem_ready) begin
                    cw.irld = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                cw.asel  = PC_SEL;
                cw.csel  = PC_SEL;
                cw.aluop = ALU_INC;
                cw.regwr = 1'b1;
                state_d  = StExec;
            end
            StExec: begin
                state_d = StFetch;
                case (op)
                    OP_ARITH: begin
                        cw.asel  = rs1;
                        cw.bsel  = rs2;
                        cw.csel  = rd;
                        cw.aluop = {2'b00, fn};
                        cw.regwr = 1'b1;
                    end
                    OP_SETLOW: begin
                        cw.csel  = rd;
                        cw.aluop = ALU_IMM;
                        cw.regwr = 1'b1;
                    end
                    OP_MEMORY: begin
                        cw.asel  = rs1;
                        cw.bsel  = rs2;
                        cw.aluop = ALU_ADD;
                        state_d  = StMem;
                    end
                    default: begin
                        if (rd == COND_HALT) begin
                            state_d = StHalt;
                        end else if (taken) begin
                            cw.asel  = PC_SEL;
                            cw.csel  = PC_SEL;
                            cw.aluop = ALU_ADDD;
                            cw.regwr = 1'b1;
                        end
                    end
                endcase
            end
            StMem: begin
                cw.asel  = rs1;
                cw.bsel  = rs2;
                cw.aluop = ALU_ADD;
                cw.memrd = ~fn[0];
                cw.memwr = fn[0];
                state_d  = StWaitMem;
            end
            StWaitMem: begin
                cw.asel  = rs1;
                cw.bsel  = rs2;
                cw.aluop = ALU_ADD;
                cw.memrd = ~fn[0];
                cw.memwr = fn[0];
                // Loads present the destination early; the write fires only on ready
                if (!fn[0]) begin
                    cw.csel = rd;
                end
                if (mem_ready) begin
                    cw.regwr = ~fn[0];
                    state_d  = StFetch;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    // Outputs are forced quiet while reset is held
    always_comb begin
        ctrlword = reset ? NOP : cw;
        halted   = (state_q == StHalt) && !reset;
        state    = state_q;
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed, table-driven bench for control_unit.
module tb_control_unit;

    logic        clk;
    logic        reset;
    logic [15:0] instruction;
    logic [4:0]  status;
    logic [19:0] ctrlword;
    logic [2:0]  state;
    logic        halted;

    int n_checks;
    int n_pass;

    typedef struct {
        logic [15:0] instr;
        logic [4:0]  stat;
        logic [2:0]  st;
        logic [19:0] cw;
        logic        hlt;
    } vec_t;

    vec_t vecs[$];

    control_unit #(
        .PC_REG (15),
        .IW     (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .status      (status),
        .ctrlword    (ctrlword),
        .state       (state),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] i, input logic [4:0] s, input logic [2:0] st,
                                input logic [19:0] cw, input logic h);
        vec_t v;
        v.instr = i;
        v.stat  = s;
        v.st    = st;
        v.cw    = cw;
        v.hlt   = h;
        return v;
    endfunction

    // Inputs change 1 time unit after the rising edge; outputs sampled 2 units later
    task automatic run_vec(input vec_t v, input int idx);
        instruction = v.instr;
        status      = v.stat;
        #2;
        check($sformatf("vec%0d state", idx), 32'(state), 32'(v.st));
        check($sformatf("vec%0d ctrlword", idx), 32'(ctrlword), 32'(v.cw));
        check($sformatf("vec%0d halted", idx), 32'(halted), 32'(v.hlt));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Pushes FETCH, WAIT_IF, DECODE rows for one instruction with memReady high
    task automatic push_front_end(input logic [15:0] i, input logic [4:0] s);
        vecs.push_back(mk(i, s, 3'd0, 20'hF0044, 1'b0));
        vecs.push_back(mk(i, s, 3'd1, 20'hF0045, 1'b0));
        vecs.push_back(mk(i, s, 3'd2, 20'hF0F58, 1'b0));
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        reset       = 1'b1;
        instruction = 16'h0000;
        status      = 5'h00;
        #2;
        check("reset ctrlword", 32'(ctrlword), 32'h0);
        check("reset halted", 32'(halted), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // add r3,r1,r2
        push_front_end(16'h8C48, 5'h01);
        vecs.push_back(mk(16'h8C48, 5'h01, 3'd3, 20'h12308, 1'b0));
        // sub r2,r4,r5
        push_front_end(16'h8915, 5'h01);
        vecs.push_back(mk(16'h8915, 5'h01, 3'd3, 20'h45218, 1'b0));
        // setlow r7
        push_front_end(16'h5C00, 5'h01);
        vecs.push_back(mk(16'h5C00, 5'h01, 3'd3, 20'h00768, 1'b0));
        // BE taken (z=1)
        push_front_end(16'h0405, 5'h09);
        vecs.push_back(mk(16'h0405, 5'h09, 3'd3, 20'hF0F78, 1'b0));
        // BE not taken (z=0)
        push_front_end(16'h0405, 5'h01);
        vecs.push_back(mk(16'h0405, 5'h01, 3'd3, 20'h00000, 1'b0));
        // undefined cond 0101 with every flag set: never taken
        push_front_end(16'h1400, 5'h1F);
        vecs.push_back(mk(16'h1400, 5'h1F, 3'd3, 20'h00000, 1'b0));
        // branch always
        push_front_end(16'h2000, 5'h01);
        vecs.push_back(mk(16'h2000, 5'h01, 3'd3, 20'hF0F78, 1'b0));
        // store r3+r4, memReady high: 6 cycles
        push_front_end(16'hC0D1, 5'h01);
        vecs.push_back(mk(16'hC0D1, 5'h01, 3'd3, 20'h34000, 1'b0));
        vecs.push_back(mk(16'hC0D1, 5'h01, 3'd4, 20'h34002, 1'b0));
        vecs.push_back(mk(16'hC0D1, 5'h01, 3'd5, 20'h34002, 1'b0));
        // fetch stall: WAIT_IF holds without irLd until memReady
        vecs.push_back(mk(16'h8C48, 5'h00, 3'd0, 20'hF0044, 1'b0));
        vecs.push_back(mk(16'h8C48, 5'h00, 3'd1, 20'hF0044, 1'b0));
        vecs.push_back(mk(16'h8C48, 5'h00, 3'd1, 20'hF0044, 1'b0));
        vecs.push_back(mk(16'h8C48, 5'h01, 3'd1, 20'hF0045, 1'b0));
        vecs.push_back(mk(16'h8C48, 5'h01, 3'd2, 20'hF0F58, 1'b0));
        vecs.push_back(mk(16'h8C48, 5'h00, 3'd3, 20'h12308, 1'b0));
        // ld r5 with three wait cycles
        push_front_end(16'hD448, 5'h01);
        vecs.push_back(mk(16'hD448, 5'h01, 3'd3, 20'h12000, 1'b0));
        vecs.push_back(mk(16'hD448, 5'h00, 3'd4, 20'h12004, 1'b0));
        vecs.push_back(mk(16'hD448, 5'h00, 3'd5, 20'h12504, 1'b0));
        vecs.push_back(mk(16'hD448, 5'h00, 3'd5, 20'h12504, 1'b0));
        vecs.push_back(mk(16'hD448, 5'h00, 3'd5, 20'h12504, 1'b0));
        vecs.push_back(mk(16'hD448, 5'h01, 3'd5, 20'h1250C, 1'b0));
        vecs.push_back(mk(16'h8C48, 5'h01, 3'd0, 20'hF0044, 1'b0));

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], i);
        end

        // Halt: sticky with memReady toggling, cleared only by reset
        do_reset();
        vecs.delete();
        push_front_end(16'h3C00, 5'h01);
        vecs.push_back(mk(16'h3C00, 5'h01, 3'd3, 20'h00000, 1'b0));
        for (int i = 0; i < 10; i++) begin
            vecs.push_back(mk(16'h3C00, (i % 2 == 0) ? 5'h00 : 5'h01, 3'd6, 20'h00000, 1'b1));
        end
        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], 100 + i);
        end
        reset  = 1'b1;
        status = 5'h01;
        #2;
        check("halt reset halted", 32'(halted), 32'h0);
        check("halt reset ctrlword", 32'(ctrlword), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("halt exit state", 32'(state), 32'h0);
        check("halt exit ctrlword", 32'(ctrlword), 32'hF0044);
        @(posedge clk);
        #1;

        // Reset during WAIT_MEM with memReady high: no regWr, back to FETCH
        do_reset();
        vecs.delete();
        push_front_end(16'hD448, 5'h01);
        vecs.push_back(mk(16'hD448, 5'h01, 3'd3, 20'h12000, 1'b0));
        vecs.push_back(mk(16'hD448, 5'h00, 3'd4, 20'h12004, 1'b0));
        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], 200 + i);
        end
        status = 5'h00;
        #1;
        check("wm state", 32'(state), 32'h5);
        reset  = 1'b1;
        status = 5'h01;
        #1;
        check("wm reset ctrlword", 32'(ctrlword), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("wm after reset state", 32'(state), 32'h0);
        check("wm after reset ctrlword", 32'(ctrlword), 32'hF0044);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter PC_REG, default 15: register-file index that holds the program counter.
REQ-002 Parameter IW, default 16: instruction width in bits.
REQ-003 Port clk  input  1: sole clock, rising edge.
REQ-004 Port reset  input  1: synchronous, active-high.
REQ-005 Port instruction  input  IW: instruction-register contents from the datapath.
REQ-006 Port status  input  5: {n,z,v,c,memReady} from the datapath.
REQ-007 Port ctrlword  output  20: {aSel[19:16], bSel[15:12], cSel[11:8], aluOp[7:4], regWr[3], memRd[2], memWr[1], irLd[0]}.
REQ-008 Port state  output  3: current FSM state, for debug.
REQ-009 Port halted  output  1: high while in HALT.

Function
REQ-010 States: FETCH=0, WAIT_IF=1, DECODE=2, EXEC=3, MEM=4, WAIT_MEM=5, HALT=6; codes 7 SHALL go to FETCH.
REQ-011 NOP ctrlword SHALL be 20'h00000.
REQ-012 ctrlword SHALL be combinational from state and instruction; irLd in WAIT_IF and regWr in WAIT_MEM additionally depend on memReady.
REQ-013 FETCH: aSel=PC_REG, aluOp=PASSA(4), memRd=1 (0xF0044); next state WAIT_IF.
REQ-014 WAIT_IF: same word; when memReady=1, irLd=1 (0xF0045) and next state DECODE; otherwise stay.
REQ-015 DECODE: aSel=cSel=PC_REG, aluOp=INC(5), regWr=1 (0xF0F58); next state EXEC.
REQ-016 Instruction fields: op[15:14], rd/cond[13:10], rs1[9:6], rs2[5:2], fn[1:0], imm/disp[9:0].
REQ-017 EXEC op=10 (arith): aSel=rs1, bSel=rs2, cSel=rd, aluOp=fn (ADD0/SUB1/AND2/OR3), regWr=1; next state FETCH.
REQ-018 EXEC op=01 (setlow): cSel=rd, aluOp=IMM(6), regWr=1; next state FETCH.
REQ-019 EXEC op=00 (branch): cond 1000 always, 0001 z, 1001 !z, 0010 n, 0011 c, 0100 v; all other codes never taken except 1111.
REQ-020 Taken branch: aSel=cSel=PC_REG, aluOp=ADDD(7), regWr=1; not taken: NOP; next state FETCH.
REQ-021 Branch cond 1111: ctrlword NOP; next state HALT.
REQ-022 Branch flags SHALL be sampled from status in the EXEC cycle.
REQ-023 EXEC op=11 (memory): aSel=rs1, bSel=rs2, aluOp=ADD, all strobes 0; next state MEM.
REQ-024 MEM: same word plus memRd=1 (fn[0]=0, load) or memWr=1 (fn[0]=1, store); next state WAIT_MEM.
REQ-025 WAIT_MEM: holds the MEM word; on memReady=1 a load adds cSel=rd and regWr=1; next state FETCH; otherwise stay.
REQ-026 memReady SHALL be ignored outside WAIT_IF and WAIT_MEM.
REQ-027 HALT: ctrlword NOP, halted=1, remain until reset.
REQ-028 Latency with memReady tied high: 4 cycles per arith, setlow, or branch instruction; 6 cycles per load/store.
REQ-029 Writes with cSel=0 SHALL still assert regWr; the datapath discards them.

Reset
REQ-030 reset=1 at a rising edge SHALL set state=FETCH, aborting any pending fetch or memory wait.
REQ-031 While reset=1: ctrlword=NOP, halted=0.

Structure
REQ-032 Package marc_pkg SHALL hold the state encoding, op/fn/cond codes, aluOp codes, ctrlword field positions, NOP and PC_REG.
REQ-033 Sub-module branch_eval (cond, n, z, v, c -> taken) SHALL be instantiated once.

Verification
REQ-034 memReady=1, instruction 0x8C48 (add r3,r1,r2) -> ctrlword sequence 0xF0044, 0xF0045, 0xF0F58, 0x12308, then FETCH.
REQ-035 instruction 0x0405 (BE disp 5), status 0x09 -> EXEC ctrlword 0xF0F78; with status 0x01 -> EXEC ctrlword 0x00000.
REQ-036 instruction 0xD448 (ld r5), memReady low for 3 WAIT_MEM cycles -> state stays 5, word 0x12504; memReady=1 -> 0x1250C, then FETCH.
REQ-037 instruction 0x3C00 -> HALT, halted=1, ctrlword 0 for 10 cycles with memReady toggling.
REQ-038 reset pulsed for one cycle during WAIT_MEM -> next cycle state=0, ctrlword 0xF0044, no regWr issued.
